// File: rtl/fir3_pkg.sv
// Shared types and constants for the 3-tap FIR filter.
// Q8.8 samples and coefficients in, Q16.16 products and sums out.
package fir3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default low-pass taps (0.25, 0.5, 0.25) sum to 1.0, so the sum cannot overflow.
    localparam logic signed [15:0] H0_DEF = 16'sd64;
    localparam logic signed [15:0] H1_DEF = 16'sd128;
    localparam logic signed [15:0] H2_DEF = 16'sd64;

    localparam int IN_FRAC_BITS  = 8;
    localparam int OUT_FRAC_BITS = 16;

endpackage

// File: rtl/fir3_mac.sv
// Combinational three-term multiply-accumulate, full-precision products, wrapping sum.
// Zero latency; no flow control.
module fir3_mac
    import fir3_pkg::*;
#(
    parameter int DATAWIDTH     = 16,
    parameter int PRODUCT_WIDTH = 32
) (
    input  logic signed [DATAWIDTH-1:0]     i_x,
    input  logic signed [DATAWIDTH-1:0]     i_d0,
    input  logic signed [DATAWIDTH-1:0]     i_d1,
    input  logic signed [DATAWIDTH-1:0]     i_h0,
    input  logic signed [DATAWIDTH-1:0]     i_h1,
    input  logic signed [DATAWIDTH-1:0]     i_h2,
    output logic signed [PRODUCT_WIDTH-1:0] o_sum
);

    localparam int EXT = PRODUCT_WIDTH - DATAWIDTH;

    // Widening both operands first keeps every product exact in PRODUCT_WIDTH bits.
    function automatic logic signed [PRODUCT_WIDTH-1:0] sext(input logic signed [DATAWIDTH-1:0] v);
        return {{EXT{v[DATAWIDTH-1]}}, v};
    endfunction

    logic signed [PRODUCT_WIDTH-1:0] w_p0;
    logic signed [PRODUCT_WIDTH-1:0] w_p1;
    logic signed [PRODUCT_WIDTH-1:0] w_p2;

    assign w_p0  = sext(i_x)  * sext(i_h0);
    assign w_p1  = sext(i_d0) * sext(i_h1);
    assign w_p2  = sext(i_d1) * sext(i_h2);
    assign o_sum = w_p0 + w_p1 + w_p2;

endmodule

// File: rtl/fir3_filter.sv
// 3-tap direct-form FIR with start/stop run control; y updates on the edge that samples x.
// No backpressure: one sample is consumed every RUN cycle without stop.
module fir3_filter
    import fir3_pkg::*;
#(
    parameter int                    DATAWIDTH     = 16,
    parameter int                    PRODUCT_WIDTH = 32,
    parameter logic signed [DATAWIDTH-1:0] H0      = H0_DEF,
    parameter logic signed [DATAWIDTH-1:0] H1      = H1_DEF,
    parameter logic signed [DATAWIDTH-1:0] H2      = H2_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    input  logic signed [DATAWIDTH-1:0]     x,
    output logic signed [PRODUCT_WIDTH-1:0] y,
    output logic                            done
);

    state_t                          r_state;
    logic signed [DATAWIDTH-1:0]     r_d0;
    logic signed [DATAWIDTH-1:0]     r_d1;
    logic signed [PRODUCT_WIDTH-1:0] r_y;
    logic                            r_done;
    logic signed [PRODUCT_WIDTH-1:0] w_sum;

    fir3_mac #(
        .DATAWIDTH     (DATAWIDTH),
        .PRODUCT_WIDTH (PRODUCT_WIDTH)
    ) u_mac (
        .i_x   (x),
        .i_d0  (r_d0),
        .i_d1  (r_d1),
        .i_h0  (H0),
        .i_h1  (H1),
        .i_h2  (H2),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_d0    <= '0;
            r_d1    <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) r_state <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_y  <= w_sum;
                        r_d1 <= r_d0;
                        r_d0 <= x;
                    end
                end
                DONE: begin
                    // A restart begins with zero history so old samples never leak in.
                    if (start) begin
                        r_state <= RUN;
                        r_done  <= 1'b0;
                        r_d0    <= '0;
                        r_d1    <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign y    = r_y;
    assign done = r_done;

endmodule

// File: tb/tb_fir3_filter.sv
// Directed bench for fir3_filter: a default-coefficient instance checked against hand values
// and an asymmetric-coefficient instance checked against a small behavioural model.
module tb_fir3_filter;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic signed [15:0] x = '0;
    logic signed [31:0] y;
    logic               done;
    logic signed [31:0] y2;
    logic               done2;

    always #5 clk = ~clk;

    fir3_filter u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .x     (x),
        .y     (y),
        .done  (done)
    );

    fir3_filter #(
        .H0 (16'sd256),
        .H1 (-16'sd128),
        .H2 (16'sd32)
    ) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .x     (x),
        .y     (y2),
        .done  (done2)
    );

    typedef struct {
        logic [31:0] y;
        logic        d;
        logic [31:0] y2;
        logic        d2;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model of the asymmetric instance, written from the run-control rules.
    int          m_st = 0;
    logic signed [15:0] m_d0 = '0;
    logic signed [15:0] m_d1 = '0;
    int          m_y2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic p, input logic [15:0] xi,
                        input logic [31:0] ey, input logic ed, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; stop = p; x = xi;
        if (r) begin
            m_st = 0; m_d0 = '0; m_d1 = '0; m_y2 = 0;
        end else begin
            case (m_st)
                0: if (s) m_st = 1;
                1: if (p) m_st = 2;
                   else begin
                       m_y2 = 256 * int'($signed(xi)) - 128 * int'(m_d0) + 32 * int'(m_d1);
                       m_d1 = m_d0;
                       m_d0 = xi;
                   end
                default: if (s) begin m_st = 1; m_d0 = '0; m_d1 = '0; end
            endcase
        end
        e.y = ey; e.d = ed; e.y2 = 32'(m_y2); e.d2 = (m_st == 2);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({tag, ".y"},     y,            e.y);
        check({tag, ".done"},  {31'd0, done},  {31'd0, e.d});
        check({tag, ".y2"},    y2,           e.y2);
        check({tag, ".done2"}, {31'd0, done2}, {31'd0, e.d2});
    endtask

    initial begin
        // reset and idle hold
        step(1, 0, 0, 16'h1234, 32'h0, 0, "rst0");
        step(1, 0, 0, 16'h1234, 32'h0, 0, "rst1");
        step(0, 0, 0, 16'h1234, 32'h0, 0, "idle0");
        step(0, 0, 1, 16'h1234, 32'h0, 0, "idle1");
        // step 0.5
        step(0, 1, 0, 16'h0080, 32'h0,        0, "s05_go");
        step(0, 0, 0, 16'h0080, 32'h00002000, 0, "s05_a");
        step(0, 0, 0, 16'h0080, 32'h00006000, 0, "s05_b");
        step(0, 0, 0, 16'h0080, 32'h00008000, 0, "s05_c");
        step(0, 0, 0, 16'h0080, 32'h00008000, 0, "s05_d");
        step(0, 0, 1, 16'h0080, 32'h00008000, 1, "s05_stop");
        step(0, 0, 1, 16'h0100, 32'h00008000, 1, "s05_hold");
        // step 0.4 after reset
        step(1, 0, 0, 16'h0066, 32'h0,   0, "s04_rst");
        step(0, 1, 0, 16'h0066, 32'h0,   0, "s04_go");
        step(0, 0, 0, 16'h0066, 32'd6528,  0, "s04_a");
        step(0, 0, 0, 16'h0066, 32'd19584, 0, "s04_b");
        step(0, 0, 0, 16'h0066, 32'd26112, 0, "s04_c");
        step(0, 0, 0, 16'h0066, 32'd26112, 0, "s04_d");
        step(0, 0, 1, 16'h0066, 32'd26112, 1, "s04_stop");
        // restart from DONE clears history; leading zero then 0.2
        step(0, 1, 0, 16'h0033, 32'd26112, 0, "s02_go");
        step(0, 0, 0, 16'h0000, 32'd0,     0, "s02_zero");
        step(0, 0, 0, 16'h0033, 32'd3264,  0, "s02_a");
        step(0, 0, 0, 16'h0033, 32'd9792,  0, "s02_b");
        step(0, 0, 0, 16'h0033, 32'd13056, 0, "s02_c");
        // start+stop in RUN: stop wins; start+stop in DONE: start wins
        step(0, 1, 1, 16'h0033, 32'd13056, 1, "both_run");
        step(0, 1, 1, 16'hFF00, 32'd13056, 0, "both_done");
        // negative step, first output only H0*x
        step(0, 0, 0, 16'hFF00, 32'hFFFFC000, 0, "neg_a");
        step(0, 0, 0, 16'hFF00, 32'hFFFF4000, 0, "neg_b");
        step(0, 0, 0, 16'hFF00, 32'hFFFF0000, 0, "neg_c");
        step(0, 1, 0, 16'h0080, 32'hFFFF6000, 0, "start_in_run");
        // reset mid-run
        step(1, 0, 0, 16'h0080, 32'h0, 0, "rst_mid");
        step(0, 0, 0, 16'h0080, 32'h0, 0, "rst_idle");
        // full-scale extremes
        step(0, 1, 0, 16'h7FFF, 32'h0,        0, "max_go");
        step(0, 0, 0, 16'h7FFF, 32'h001FFFC0, 0, "max_a");
        step(0, 0, 0, 16'h7FFF, 32'h005FFF40, 0, "max_b");
        step(0, 0, 0, 16'h7FFF, 32'h007FFF00, 0, "max_c");
        step(0, 0, 0, 16'h8000, 32'h003FFF40, 0, "min_a");
        step(0, 0, 0, 16'h8000, 32'hFFBFFFC0, 0, "min_b");
        step(0, 0, 1, 16'h0000, 32'hFFBFFFC0, 1, "min_stop");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir3_filter.md
Name: fir3_filter

Overview:
- 3-tap direct-form FIR filter on a signed Q8.8 sample stream. Output is Q16.16 in PRODUCT_WIDTH.
- A start/stop handshake gates processing. `done` flags that a filtering run has completed.
- Leaf DSP block; its instantiating top supplies one new sample per clock while running.

Parameters:
- DATAWIDTH, 16: sample width, signed two's complement, Q8.8.
- PRODUCT_WIDTH, 32: output/accumulator width, signed, Q16.16. Must be 2*DATAWIDTH.
- H0, 16'sd64: coefficient for x[n], Q8.8 (0.25).
- H1, 16'sd128: coefficient for x[n-1], Q8.8 (0.5).
- H2, 16'sd64: coefficient for x[n-2], Q8.8 (0.25).

Ports:
- clk  in  1  rising-edge clock. One clock domain; synchronous and active-high reset.
- rst  in  1  synchronous active-high reset.
- start  in  1  level; begins a run when sampled high in IDLE or DONE.
- stop  in  1  level; ends a run when sampled high in RUN.
- x  in  DATAWIDTH  signed input sample, Q8.8.
- y  out  PRODUCT_WIDTH  signed registered filter output, Q16.16.
- done  out  1  high while in DONE state.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - Delay regs d0=d1=0.
  - y=0, done=0.
  - rst has priority over all other inputs, including mid-run.
- States:
  - IDLE: start=1 -> RUN. Otherwise stay. Nothing samples; y holds.
  - RUN:
    - stop=1 -> DONE. No sample taken that edge; y holds.
    - stop=0 -> stay in RUN and sample.
    - start is ignored in RUN. Simultaneous start+stop: stop wins.
  - DONE:
    - done=1; y holds its last value.
    - start=1 -> clear d0, d1, go to RUN, done=0 next cycle. stop is ignored in DONE.
- Sampling, each posedge in RUN with stop=0:
  - y <= H0*x + H1*d0 + H2*d1
  - d1 <= d0; d0 <= x
- Latency:
  - y reflects sample x one clock after x is presented.
  - First RUN edge uses d0=d1=0 (zero initial history).
- Arithmetic:
  - Each product is a full-precision signed DATAWIDTH x DATAWIDTH -> PRODUCT_WIDTH multiply.
  - The three-term sum wraps modulo 2^PRODUCT_WIDTH. No saturation and no rounding.
  - With default coefficients (sum = 1.0) no overflow is possible.
- done is registered, asserted the cycle after the RUN->DONE edge, and deasserted on rst or start.

Decomposition:
- Package fir3_pkg:
  - state enum {IDLE, RUN, DONE}
  - default coefficient constants H0/H1/H2
  - Q-format fraction-bit constants (8 in, 16 out)
- One sub-module is natural: fir3_mac. It is combinational; given x, d0, d1 and the coefficients it returns the PRODUCT_WIDTH sum.
- The top holds the FSM, delay registers and output register.

Test Plan:
- Reset: rst=1 for 2 cycles with x=0x1234 -> y=0, done=0, and y unchanged afterward while idle.
- Step 0.5: start, then x=0x0080 each RUN cycle -> y sequence 0x00002000, 0x00006000, 0x00008000, then 0x00008000 steady. stop -> done=1 next cycle, y holds 0x00008000.
- Step 0.4 after rst: x=0x0066 -> y = 6528, 19584, 26112, 26112 (decimal). After stop, done=1.
- Leading zero then 0.2: start one cycle with x=0, then x=0x0033 -> y = 0, 3264, 9792, 13056.
- Negative: x=0xFF00 (-1.0) step -> y = 0xFFFFC000, 0xFFFF4000, 0xFFFF0000.
- Control edges:
  - start+stop together in RUN -> DONE.
  - start in DONE -> RUN with cleared history: the first y uses only H0*x.
  - rst mid-RUN -> IDLE, y=0 next cycle.
